// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types for the gray_counter slice.
package gray_pkg;

  localparam int unsigned GRAY_MAX_WIDTH = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/converter_gray2bin.sv
// Combinational Gray-to-binary decoder for receivers of gray_counter's count_gray.
module converter_gray2bin #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_gray,
  output logic [DATA_WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[DATA_WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with coherent registered Gray output, load, wrap/saturate and terminal flag.
// Define GRAY_COUNTER_ASSERT_EN to compile in the SVA checks.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [DATA_WIDTH-1:0] count_bin,
  output logic [DATA_WIDTH-1:0] count_gray,
  output logic                  terminal
);

  localparam logic [DATA_WIDTH-1:0] RESET_BIN  = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

  logic [DATA_WIDTH-1:0] r_bin, r_gray;
  logic                  r_term;

  logic [DATA_WIDTH:0]   w_inc, w_dec;
  logic [DATA_WIDTH-1:0] w_next_bin, w_next_gray;
  logic                  w_next_term;
  count_dir_e            w_dir;

  // The extra MSB is the carry/borrow that marks a boundary crossing.
  assign w_inc = {1'b0, r_bin} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, r_bin} - {{DATA_WIDTH{1'b0}}, 1'b1};
  assign w_dir = count_dir_e'(up);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    w_next_bin  = r_bin;
    w_next_term = 1'b0;
    if (load) begin
      w_next_bin = load_value;
    end else if (en) begin
      if (w_dir == DIR_UP) begin
        w_next_term = w_inc[DATA_WIDTH];
        if (!(SATURATE && w_inc[DATA_WIDTH])) w_next_bin = w_inc[DATA_WIDTH-1:0];
      end else begin
        w_next_term = w_dec[DATA_WIDTH];
        if (!(SATURATE && w_dec[DATA_WIDTH])) w_next_bin = w_dec[DATA_WIDTH-1:0];
      end
    end
  end

  // Gray is taken from the next binary value so both registers always agree.
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    if (rst) begin
      r_bin  <= RESET_BIN;
      r_gray <= RESET_GRAY;
      r_term <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_term <= w_next_term;
    end
  end

  assign count_bin  = r_bin;
  assign count_gray = r_gray;
  assign terminal   = r_term;

`ifdef GRAY_COUNTER_ASSERT_EN
  a_coherent : assert property (@(posedge clk) disable iff (rst)
    32'(count_gray) == bin2gray(32'(count_bin)))
    else $error("gray_counter: count_gray incoherent with count_bin");

  a_one_bit : assert property (@(posedge clk) disable iff (rst)
    ($past(en) && !$past(load) && !$past(rst)) |->
      ($countones(count_gray ^ $past(count_gray)) <= 1))
    else $error("gray_counter: step changed more than one Gray bit");

  a_term_cause : assert property (@(posedge clk) disable iff (rst)
    terminal |-> $past(en || load))
    else $error("gray_counter: terminal without a step");
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed and model-checked bench for gray_counter (8-bit wrap, 4-bit wrap, 4-bit saturate).
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] lv;

  logic [7:0] u8_bin, u8_gray, conv_bin;
  logic       u8_term;
  logic [3:0] w4_bin, w4_gray, s4_bin, s4_gray;
  logic       w4_term, s4_term;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_counter #(.DATA_WIDTH(8), .SATURATE(1'b0), .RESET_VALUE(5)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(lv),
    .count_bin(u8_bin), .count_gray(u8_gray), .terminal(u8_term));

  gray_counter #(.DATA_WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(0)) u_dut4w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(lv[3:0]),
    .count_bin(w4_bin), .count_gray(w4_gray), .terminal(w4_term));

  gray_counter #(.DATA_WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(0)) u_dut4s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(lv[3:0]),
    .count_bin(s4_bin), .count_gray(s4_gray), .terminal(s4_term));

  converter_gray2bin #(.DATA_WIDTH(8)) u_conv (.i_gray(u8_gray), .o_bin(conv_bin));

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int g(input int b);
    return b ^ (b >> 1);
  endfunction

  // Reference next-state for one cycle of a counter of width w.
  function automatic int model_step(input int cur, input int w, input bit sat, input int rv,
                                    input bit r, input bit l, input bit e, input bit u,
                                    input int ld, output bit t);
    int mx;
    mx = (1 << w) - 1;
    t  = 1'b0;
    if (r) return rv;
    if (l) return ld & mx;
    if (!e) return cur;
    if (u) begin
      if (cur == mx) begin t = 1'b1; return sat ? mx : 0; end
      return cur + 1;
    end
    if (cur == 0) begin t = 1'b1; return sat ? 0 : mx; end
    return cur - 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; lv = 8'h00;
    tick(); tick();
    n_checks++;
    if ({u8_bin, u8_gray, u8_term} !== {8'd5, 8'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_u8: got bin=%0d gray=%0d term=%0b, want 5 7 0", u8_bin, u8_gray, u8_term);
    end
    n_checks++;
    if ({w4_bin, w4_gray, w4_term, s4_bin, s4_gray, s4_term} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_u4: got w=%0d/%0d/%0b s=%0d/%0d/%0b, want all 0",
               w4_bin, w4_gray, w4_term, s4_bin, s4_gray, s4_term);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({u8_bin, u8_gray, u8_term} !== {8'd5, 8'd7, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_u8[%0d]: got bin=%0d gray=%0d term=%0b, want 5 7 0", i, u8_bin, u8_gray, u8_term);
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] eb [3] = '{4'd15, 4'd0, 4'd1};
    logic [3:0] eg [3] = '{4'd8, 4'd0, 4'd1};
    logic       et [3] = '{1'b0, 1'b1, 1'b0};
    lv = 8'd14; load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if ({w4_bin, w4_gray, w4_term} !== {4'd14, 4'd9, 1'b0}) begin
      n_fail++;
      $display("FAIL load14: got %0d/%0d/%0b, want 14/9/0", w4_bin, w4_gray, w4_term);
    end
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({w4_bin, w4_gray, w4_term} !== {eb[i], eg[i], et[i]}) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: got %0d/%0d/%0b, want %0d/%0d/%0b",
                 i, w4_bin, w4_gray, w4_term, eb[i], eg[i], et[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_down_saturate();
    logic [3:0] wb [3] = '{4'd15, 4'd14, 4'd13};
    logic [3:0] wg [3] = '{4'd8, 4'd9, 4'd11};
    logic       wt [3] = '{1'b1, 1'b0, 1'b0};
    lv = 8'd0; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({w4_bin, w4_gray, w4_term} !== {wb[i], wg[i], wt[i]}) begin
        n_fail++;
        $display("FAIL wrap_down[%0d]: got %0d/%0d/%0b, want %0d/%0d/%0b",
                 i, w4_bin, w4_gray, w4_term, wb[i], wg[i], wt[i]);
      end
      n_checks++;
      if ({s4_bin, s4_gray, s4_term} !== {4'd0, 4'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL sat_low[%0d]: got %0d/%0d/%0b, want 0/0/1", i, s4_bin, s4_gray, s4_term);
      end
    end
    en = 1'b0; lv = 8'd15; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({s4_bin, s4_gray, s4_term} !== {4'd15, 4'd8, 1'b1}) begin
        n_fail++;
        $display("FAIL sat_high[%0d]: got %0d/%0d/%0b, want 15/8/1", i, s4_bin, s4_gray, s4_term);
      end
    end
    en = 1'b0; lv = 8'd14; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    en = 1'b0;
    n_checks++;
    if ({s4_bin, s4_gray, s4_term} !== {4'd15, 4'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_reach: got %0d/%0d/%0b, want 15/8/0", s4_bin, s4_gray, s4_term);
    end
  endtask

  task automatic test_priority();
    lv = 8'h3C; load = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    n_checks++;
    if ({u8_bin, u8_gray, u8_term} !== {8'h3C, 8'h22, 1'b0}) begin
      n_fail++;
      $display("FAIL load_over_en: got %0h/%0h/%0b, want 3c/22/0", u8_bin, u8_gray, u8_term);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    n_checks++;
    if ({u8_bin, u8_gray, u8_term} !== {8'd5, 8'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_over_load: got %0d/%0d/%0b, want 5/7/0", u8_bin, u8_gray, u8_term);
    end
  endtask

  task automatic test_gray_sweep();
    logic [7:0] prev;
    lv = 8'd0; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    prev = u8_gray;
    for (int k = 1; k <= 512; k++) begin
      tick();
      n_checks++;
      if ({u8_bin, u8_term} !== {8'(k), (k % 256) == 0}) begin
        n_fail++;
        $display("FAIL sweep_cnt[%0d]: got bin=%0d term=%0b, want bin=%0d term=%0b",
                 k, u8_bin, u8_term, k % 256, (k % 256) == 0);
      end
      n_checks++;
      if ($countones(u8_gray ^ prev) != 1) begin
        n_fail++;
        $display("FAIL sweep_onebit[%0d]: gray %0h -> %0h", k, prev, u8_gray);
      end
      n_checks++;
      if (conv_bin !== 8'(k)) begin
        n_fail++;
        $display("FAIL sweep_decode[%0d]: got %0d, want %0d", k, conv_bin, k % 256);
      end
      prev = u8_gray;
    end
    en = 1'b0;
  endtask

  task automatic test_random_mix();
    int m8, mw, ms;
    bit t8, tw, ts;
    for (int c = 0; c < 10000; c++) begin
      rst  = (c == 0) || ($urandom_range(63) == 0);
      load = ($urandom_range(7) == 0);
      en   = ($urandom_range(3) != 0);
      up   = $urandom_range(1);
      lv   = 8'($urandom_range(255));
      m8 = model_step(m8, 8, 1'b0, 5, rst, load, en, up, int'(lv), t8);
      mw = model_step(mw, 4, 1'b0, 0, rst, load, en, up, int'(lv), tw);
      ms = model_step(ms, 4, 1'b1, 0, rst, load, en, up, int'(lv), ts);
      tick();
      n_checks++;
      if ({u8_bin, u8_gray, u8_term} !== {8'(m8), 8'(g(m8)), t8}) begin
        n_fail++;
        $display("FAIL rand_u8[%0d]: got %0d/%0d/%0b, want %0d/%0d/%0b",
                 c, u8_bin, u8_gray, u8_term, m8, g(m8), t8);
      end
      n_checks++;
      if ({w4_bin, w4_gray, w4_term} !== {4'(mw), 4'(g(mw)), tw}) begin
        n_fail++;
        $display("FAIL rand_w4[%0d]: got %0d/%0d/%0b, want %0d/%0d/%0b",
                 c, w4_bin, w4_gray, w4_term, mw, g(mw), tw);
      end
      n_checks++;
      if ({s4_bin, s4_gray, s4_term} !== {4'(ms), 4'(g(ms)), ts}) begin
        n_fail++;
        $display("FAIL rand_s4[%0d]: got %0d/%0d/%0b, want %0d/%0d/%0b",
                 c, s4_bin, s4_gray, s4_term, ms, g(ms), ts);
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down_saturate();
    test_priority();
    test_gray_sweep();
    test_random_mix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
